// File: rtl/fifo_ctrl.sv
// Circular FIFO controller for an external 8x12 dual-pointer memory.
// Clears the memory after reset, then runs a push/pop client interface.
module fifo_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic                  write,
    output logic                  read,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  busy,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  in_run;
    logic                  pop_acc;
    logic                  push_acc;

    assign in_run = (state == S_RUN);

    assign count        = cnt;
    assign full         = in_run && (cnt == DEPTH_C);
    assign empty        = !in_run || (cnt == '0);
    assign almost_full  = (cnt >= AF_C);
    assign almost_empty = (cnt <= AE_C);
    assign busy         = !in_run;

    // A pop frees a slot in the same cycle, so push at full is legal with it.
    assign pop_acc  = in_run && pop && !empty;
    assign push_acc = in_run && push && (!full || pop_acc);

    // Memory port mux: zero-fill sweep during INIT, client traffic in RUN.
    always_comb begin
        write  = push_acc;
        data   = din;
        wr_ptr = wptr;
        read   = pop_acc;
        rd_ptr = rptr;
        if (!in_run) begin
            write  = 1'b1;
            data   = '0;
            wr_ptr = init_cnt;
            read   = 1'b0;
        end
    end

    // Popped word comes straight from the memory's registered output.
    assign dout = dout_valid ? q : '0;

    // INIT sweep sequencing; leaves INIT after writing the last address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_INIT;
            init_cnt <= '0;
        end else if (!in_run) begin
            init_cnt <= init_cnt + 1'b1;
            if (&init_cnt) begin
                state <= S_RUN;
            end
        end
    end

    // Pointer and occupancy bookkeeping for accepted transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_acc) begin
                rptr <= rptr + 1'b1;
            end
            if (push_acc && !pop_acc) begin
                cnt <= cnt + 1'b1;
            end else if (pop_acc && !push_acc) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Read-data qualifier: one pulse per accepted pop, a cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= pop_acc;
        end
    end

    // Sticky error flags for rejected requests while running.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (in_run) begin
            if (push && full && !pop_acc) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized scoreboard bench for fifo_ctrl with an attached memory model.
// Expected words are queued on accepted pops and checked by a monitor.
module tb_fifo_ctrl;

    logic        clk;
    logic        reset;
    logic        push;
    logic        pop;
    logic [11:0] din;
    logic [11:0] q;
    logic [11:0] data;
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic        write;
    logic        read;
    logic [11:0] dout;
    logic        dout_valid;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic        busy;
    logic        overflow;
    logic        underflow;

    fifo_ctrl dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
        .q(q), .data(data), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
        .write(write), .read(read), .dout(dout), .dout_valid(dout_valid),
        .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .busy(busy), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: synchronous write, registered read (read-before-write).
    logic [11:0] mem [8];
    initial for (int i = 0; i < 8; i++) mem[i] = 12'(i * 291 + 5);
    always @(posedge clk) begin
        if (write === 1'b1) mem[wr_ptr] <= data;
        if (read === 1'b1) q <= mem[rd_ptr];
    end

    int checks = 0;
    int failures = 0;

    // Reference model state.
    logic [11:0] mq[$];
    logic [11:0] sb[$];
    bit m_init, m_ovf, m_unf, m_vld, known;
    int init_idx, wp, rp;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: every dout_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dout_unexpected: got 0x%0h with no pop pending", dout);
            end else begin
                chk("dout", int'(dout), int'(sb.pop_front()));
            end
        end
    end

    task automatic check_outputs(input bit pu, input bit po, input logic [11:0] d);
        bit pa, ua;
        int n;
        n = mq.size();
        if (m_init) begin
            chk("init_busy", int'(busy), 1);
            chk("init_write", int'(write), 1);
            chk("init_data", int'(data), 0);
            chk("init_wr_ptr", int'(wr_ptr), init_idx);
            chk("init_read", int'(read), 0);
            chk("init_empty", int'(empty), 1);
            chk("init_full", int'(full), 0);
            chk("init_count", int'(count), 0);
        end else begin
            pa = po && n > 0;
            ua = pu && (n < 8 || pa);
            chk("busy", int'(busy), 0);
            chk("write", int'(write), int'(ua));
            chk("read", int'(read), int'(pa));
            if (ua) chk("wr_ptr", int'(wr_ptr), wp);
            if (ua) chk("data", int'(data), int'(d));
            if (pa) chk("rd_ptr", int'(rd_ptr), rp);
            chk("count", int'(count), n);
            chk("full", int'(full), int'(n == 8));
            chk("empty", int'(empty), int'(n == 0));
            chk("almost_full", int'(almost_full), int'(n >= 6));
            chk("almost_empty", int'(almost_empty), int'(n <= 2));
        end
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_unf));
        chk("dout_valid", int'(dout_valid), int'(m_vld));
    endtask

    task automatic update(input bit r, input bit pu, input bit po, input logic [11:0] d);
        bit pa, ua;
        int n;
        n = mq.size();
        if (r) begin
            known = 1;
            m_init = 1;
            init_idx = 0;
            mq.delete();
            wp = 0;
            rp = 0;
            m_ovf = 0;
            m_unf = 0;
            m_vld = 0;
        end else if (m_init) begin
            init_idx++;
            if (init_idx == 8) m_init = 0;
            m_vld = 0;
        end else begin
            pa = po && n > 0;
            ua = pu && (n < 8 || pa);
            if (pu && n == 8 && !pa) m_ovf = 1;
            if (po && n == 0) m_unf = 1;
            if (pa) begin
                sb.push_back(mq.pop_front());
                rp = (rp + 1) % 8;
            end
            if (ua) begin
                mq.push_back(d);
                wp = (wp + 1) % 8;
            end
            m_vld = pa;
        end
    endtask

    task automatic cycle(input bit r, input bit pu, input bit po, input logic [11:0] d);
        @(posedge clk);
        #1;
        reset = r;
        push = pu;
        pop = po;
        din = d;
        @(negedge clk);
        if (known) check_outputs(pu, po, d);
        update(r, pu, po, d);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 12'h0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 12'h0);
    endtask

    logic [11:0] words [4];

    initial begin
        reset = 1'b1;
        push = 1'b0;
        pop = 1'b0;
        din = '0;
        known = 0;
        words[0] = 12'h123;
        words[1] = 12'hABC;
        words[2] = 12'h456;
        words[3] = 12'hDEF;

        cycle(1, 0, 0, 12'h0);
        do_reset();
        cycle(0, 0, 0, 12'h0);

        for (int i = 0; i < 4; i++) cycle(0, 1, 0, words[i]);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 12'h0);
        cycle(0, 0, 0, 12'h0);
        cycle(0, 0, 0, 12'h0);

        for (int i = 0; i < 9; i++) cycle(0, 1, 0, 12'(12'h200 + i));
        cycle(0, 0, 1, 12'h0);
        cycle(0, 0, 1, 12'h0);
        cycle(0, 0, 0, 12'h0);

        do_reset();
        cycle(0, 1, 1, 12'h055);
        cycle(0, 0, 0, 12'h0);

        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 12'(12'h300 + i));
        for (int i = 0; i < 12; i++) cycle(0, 1, 1, 12'(12'h777 + i));
        for (int i = 0; i < 9; i++) cycle(0, 0, 1, 12'h0);
        cycle(0, 0, 0, 12'h0);

        for (int i = 0; i < 400; i++) begin
            int pp;
            pp = ((i / 50) % 2 == 0) ? 75 : 25;
            cycle(0, $urandom_range(0, 99) < pp, $urandom_range(0, 99) < 100 - pp,
                  12'($urandom_range(0, 4095)));
        end

        do_reset();
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 12'(12'h500 + i));
        cycle(0, 0, 1, 12'h0);
        cycle(0, 1, 0, 12'h5AA);
        do_reset();
        cycle(0, 0, 1, 12'h0);
        cycle(0, 0, 0, 12'h0);
        cycle(0, 0, 0, 12'h0);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
